// File: rtl/ifq_pkg.sv
// ifq_pkg: shared widths and types for the instruction fetch queue.
//   CPU_WIDTH   - PC width
//   INS_WIDTH   - instruction word width
//   ENTRY_WIDTH - width of one queued {pc, ins} entry
//   IFQ_DEPTH   - default queue depth
//   ifq_entry_t - packed {pc, ins} queue entry
package ifq_pkg;

  localparam int unsigned CPU_WIDTH   = 32;
  localparam int unsigned INS_WIDTH   = 32;
  localparam int unsigned ENTRY_WIDTH = CPU_WIDTH + INS_WIDTH;
  localparam int unsigned IFQ_DEPTH   = 4;

  typedef struct packed {
    logic [CPU_WIDTH-1:0] pc;
    logic [INS_WIDTH-1:0] ins;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_mem.sv
// ifq_mem: DEPTH x entry register array for the fetch queue.
// Ports:
//   i_clk   - clock
//   i_we    - write enable
//   i_waddr - write index
//   i_wdata - entry to write
//   i_raddr - read index (asynchronous read)
//   o_rdata - entry at i_raddr
// Storage is intentionally not reset.
module ifq_mem
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  ifq_entry_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output ifq_entry_t    o_rdata
);

  ifq_entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifq.sv
// ifq: instruction fetch queue between fetch (producer) and decode (consumer).
// Ports:
//   i_clk, i_rst          - clock, synchronous active-high reset
//   i_pre_valid/o_pre_ready, i_pc, i_ins  - fetch side handshake and beat
//   o_post_valid/i_post_ready, o_pc, o_ins - decode side handshake and head
//   i_flush               - drop all entries and any same-cycle input
//   o_count               - occupancy, 0..DEPTH
// Optional feature macro: IFQ_BYPASS_EN
//   When defined, an empty queue forwards the input beat combinationally to
//   decode; if decode takes it that cycle, nothing is written.
module ifq
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [INS_WIDTH-1:0] i_ins,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic [INS_WIDTH-1:0] o_ins,
  input  logic                 i_flush,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_empty;
  logic         w_full;
  logic         w_push;
  logic         w_pop;
  logic         w_byp;
  ifq_entry_t   w_wdata;
  ifq_entry_t   w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_wdata = '{pc: i_pc, ins: i_ins};

  ifq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_head)
  );

  assign o_pre_ready = !w_full;

`ifdef IFQ_BYPASS_EN
  assign w_byp = w_empty && i_pre_valid && !i_flush;
`else
  assign w_byp = 1'b0;
`endif

  always_comb begin
    o_post_valid = !w_empty || w_byp;
    o_pc         = w_head.pc;
    o_ins        = w_head.ins;
    if (w_byp) begin
      o_pc  = i_pc;
      o_ins = i_ins;
    end
    // A bypassed beat that decode takes immediately is never stored.
    w_push = i_pre_valid && !w_full && !i_flush && !(w_byp && i_post_ready);
    // Pops only ever come from storage; bypass consumption leaves rd_ptr alone.
    w_pop  = !w_empty && i_post_ready && !i_flush;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_ifq.sv
module tb_ifq;
  import ifq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_pre_valid;
  logic                 o_pre_ready;
  logic [CPU_WIDTH-1:0] i_pc;
  logic [INS_WIDTH-1:0] i_ins;
  logic                 o_post_valid;
  logic                 i_post_ready;
  logic [CPU_WIDTH-1:0] o_pc;
  logic [INS_WIDTH-1:0] o_ins;
  logic                 i_flush;
  logic [AW:0]          o_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ifq_entry_t sb[$];
  logic       last_acc;

  always #5 i_clk = ~i_clk;

  ifq #(
    .DEPTH (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .i_pc         (i_pc),
    .i_ins        (i_ins),
    .o_post_valid (o_post_valid),
    .i_post_ready (i_post_ready),
    .o_pc         (o_pc),
    .o_ins        (o_ins),
    .i_flush      (i_flush),
    .o_count      (o_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model at the
  // falling edge, then advance the model by the handshakes that occur.
  task automatic cycle(input logic rst, input logic pv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic pr, input logic fl);
    logic       exp_ready;
    logic       exp_valid;
    logic       byp;
    logic       accepted;
    ifq_entry_t head;
    i_rst        = rst;
    i_pre_valid  = pv;
    i_pc         = pc;
    i_ins        = ins;
    i_post_ready = pr;
    i_flush      = fl;
    @(negedge i_clk);
    last_acc = 1'b0;
    if (rst) begin
      sb.delete();
    end else begin
      exp_ready = (sb.size() < DEPTH);
      byp = 1'b0;
`ifdef IFQ_BYPASS_EN
      byp = (sb.size() == 0) && pv && !fl;
`endif
      exp_valid = (sb.size() != 0) || byp;
      check("count", 64'(o_count), 64'(sb.size()));
      check("pre_ready", 64'(o_pre_ready), 64'(exp_ready));
      check("post_valid", 64'(o_post_valid), 64'(exp_valid));
      if (exp_valid) begin
        head = byp ? '{pc: pc, ins: ins} : sb[0];
        check("pc", 64'(o_pc), 64'(head.pc));
        check("ins", 64'(o_ins), 64'(head.ins));
      end
      accepted = pv && exp_ready && !fl;
      last_acc = accepted;
      if (fl) begin
        sb.delete();
      end else if (!(byp && pr)) begin
        if (exp_valid && pr) void'(sb.pop_front());
        if (accepted) sb.push_back('{pc: pc, ins: ins});
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        cur_pv;
    logic [31:0] cur_pc;
    logic [31:0] cur_ins;
    logic        cur_fl;

    // Reset with fetch asserting valid: nothing may be accepted.
    cycle(1'b1, 1'b1, 32'h8000_0000, 32'h13, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_0000, 32'h13, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill with decode stalled; fifth beat is held off while full.
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 1'b1, 32'h8000_0000 + 32'(4*k), 32'h13 + 32'(k), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0010, 32'h17, 1'b0, 1'b0);
    // Full with simultaneous pop: pop only, push lands next cycle.
    cycle(1'b0, 1'b1, 32'h8000_0010, 32'h17, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0010, 32'h17, 1'b0, 1'b0);
    // Drain in order.
    for (int k = 0; k < 5; k++)
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Wrap-around: 10 back-to-back beats with decode always ready.
    for (int k = 0; k < 10; k++)
      cycle(1'b0, 1'b1, 32'h8000_0400 + 32'(4*k), 32'hA000 + 32'(k), 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with three queued and a same-cycle input beat.
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b1, 32'h8000_0080 + 32'(4*k), 32'hB000 + 32'(k), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0100, 32'hDEAD, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h8000_0200, 32'hBEEF, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty queue, beat with decode ready (bypass or one-cycle latency).
    cycle(1'b0, 1'b1, 32'h8000_0040, 32'h33, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset mid-stream drops queued entries.
    cycle(1'b0, 1'b1, 32'h8000_0300, 32'h44, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_0304, 32'h45, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_0308, 32'h46, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic obeying the hold-until-accepted rule.
    cur_pv = 1'b0; cur_pc = '0; cur_ins = '0; cur_fl = 1'b0;
    for (int unsigned n = 0; n < 400; n++) begin
      if (!cur_pv || last_acc || cur_fl) begin
        cur_pv  = ($urandom_range(0, 3) != 0);
        cur_pc  = 32'h8001_0000 + 32'(4*n);
        cur_ins = $urandom;
      end
      cur_fl = ($urandom_range(0, 24) == 0);
      cycle(1'b0, cur_pv, cur_pc, cur_ins, ($urandom_range(0, 2) != 0), cur_fl);
    end
    for (int k = 0; k < 6; k++)
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
